// File: rtl/imem_arbiter_if.sv
// Bus between the CPU core (fetch/data ports), the code ROM and imem_arbiter.
// The master side is the core plus ROM. The slave side is the arbiter.
interface imem_arbiter_if;
   logic        f_req;
   logic [30:0] f_addr;
   logic        f_gnt;
   logic        f_rvalid;
   logic [31:0] f_rdata;
   logic        f_err;

   logic        d_req;
   logic [30:0] d_addr;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;

   logic [30:0] rom_addr;
   logic [31:0] rom_data;
   logic        busy;

   modport master (
      output f_req, f_addr, d_req, d_addr, rom_data,
      input  f_gnt, f_rvalid, f_rdata, f_err,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  rom_addr, busy
   );

   modport slave (
      input  f_req, f_addr, d_req, d_addr, rom_data,
      output f_gnt, f_rvalid, f_rdata, f_err,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output rom_addr, busy
   );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-ported code ROM between the fetch and data ports, with programmable wait states.
// Define IMEM_ARB_RANGE_CHK_EN to flag and short-circuit accesses beyond ROM_WORDS.
module imem_arbiter #(
   parameter int WAIT_STATES  = 0,
   parameter int STARVE_LIMIT = 3,
   parameter int ROM_WORDS    = 32
) (
   input logic           clk,
   input logic           reset,
   imem_arbiter_if.slave bus
);

   typedef enum logic {IDLE, ACCESS} state_t;

   if (WAIT_STATES < 0 || WAIT_STATES > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15 ||
       ROM_WORDS < 1) begin : g_bad_param
      $error("imem_arbiter: parameter out of range");
   end

   state_t      state_reg;
   logic [3:0]  cnt_reg;
   logic [3:0]  starve_reg;
   logic        owner_reg;      // 1 = data port owns the current access
   logic        oor_reg;
   logic        busy_reg;
   logic [30:0] rom_addr_reg;
   logic        f_rvalid_reg, d_rvalid_reg;
   logic [31:0] f_rdata_reg, d_rdata_reg;
   logic        f_err_reg, d_err_reg;

   logic        fetch_wins, data_wins;
   logic        f_gnt_w, d_gnt_w;
   logic [30:0] grant_addr;
   logic        grant_oor;
   logic [31:0] access_word;

   // Fetch takes the slot once it has lost STARVE_LIMIT times in a row, otherwise data has priority.
   assign fetch_wins = bus.f_req && (starve_reg == 4'(STARVE_LIMIT) || !bus.d_req);
   assign data_wins  = bus.d_req && !fetch_wins;
   assign f_gnt_w    = !reset && state_reg == IDLE && fetch_wins;
   assign d_gnt_w    = !reset && state_reg == IDLE && data_wins;
   assign grant_addr = data_wins ? bus.d_addr : bus.f_addr;

`ifdef IMEM_ARB_RANGE_CHK_EN
   assign grant_oor = ({2'b00, grant_addr[30:2]} >= 31'(ROM_WORDS));
`else
   assign grant_oor = 1'b0;
`endif

   assign access_word = oor_reg ? 32'd0 : bus.rom_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         starve_reg   <= '0;
         owner_reg    <= 1'b0;
         oor_reg      <= 1'b0;
         busy_reg     <= 1'b0;
         rom_addr_reg <= '0;
         f_rvalid_reg <= 1'b0;
         d_rvalid_reg <= 1'b0;
         f_rdata_reg  <= '0;
         d_rdata_reg  <= '0;
         f_err_reg    <= 1'b0;
         d_err_reg    <= 1'b0;
      end else begin
         f_rvalid_reg <= 1'b0;
         d_rvalid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (f_gnt_w || d_gnt_w) begin
                  state_reg    <= ACCESS;
                  busy_reg     <= 1'b1;
                  owner_reg    <= d_gnt_w;
                  oor_reg      <= grant_oor;
                  rom_addr_reg <= grant_addr;
                  cnt_reg      <= grant_oor ? 4'd0 : 4'(WAIT_STATES);
                  if (f_gnt_w)
                     starve_reg <= '0;
                  else if (bus.f_req && starve_reg != 4'hF)
                     starve_reg <= starve_reg + 4'd1;
               end
            end
            ACCESS: begin
               if (cnt_reg != 4'd0) begin
                  cnt_reg <= cnt_reg - 4'd1;
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  if (owner_reg) begin
                     d_rvalid_reg <= 1'b1;
                     d_rdata_reg  <= access_word;
                     d_err_reg    <= oor_reg;
                  end else begin
                     f_rvalid_reg <= 1'b1;
                     f_rdata_reg  <= access_word;
                     f_err_reg    <= oor_reg;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.f_gnt    = f_gnt_w;
   assign bus.d_gnt    = d_gnt_w;
   assign bus.f_rvalid = f_rvalid_reg;
   assign bus.d_rvalid = d_rvalid_reg;
   assign bus.f_rdata  = f_rdata_reg;
   assign bus.d_rdata  = d_rdata_reg;
   assign bus.f_err    = f_err_reg;
   assign bus.d_err    = d_err_reg;
   assign bus.rom_addr = rom_addr_reg;
   assign bus.busy     = busy_reg;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized bench for imem_arbiter against a transaction-level model of grants and completions.
// Honours IMEM_ARB_RANGE_CHK_EN the same way the design does.
module tb_imem_arbiter;
   localparam int WS = 2;
   localparam int SL = 3;
   localparam int RW = 32;

   typedef struct {
      int          done;
      logic        port;     // 1 = data
      logic [31:0] data;
      logic        err;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   imem_arbiter_if bus();

   imem_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(SL), .ROM_WORDS(RW)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] rom_mem [64];
   assign bus.rom_data = rom_mem[bus.rom_addr[7:2]];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          free_cyc = 0;
   int          starve   = 0;
   int          last_grant = -10;
   logic        prev_rst = 1'b1;
   logic        f_pend = 1'b0, d_pend = 1'b0;
   logic [30:0] f_a = '0, d_a = '0;
   logic [31:0] exp_f_rdata = '0, exp_d_rdata = '0;
   logic        exp_f_err = 1'b0, exp_d_err = 1'b0;
   logic [30:0] exp_rom_addr = '0;
   ev_t         evq[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [30:0] rand_addr(input int oor_pct);
      logic [30:0] a;
      int          w;
      if (int'($urandom_range(99)) < oor_pct) w = int'($urandom_range(63, RW));
      else                                    w = int'($urandom_range(RW - 1));
      a = 31'(w) << 2;
      a[1:0] = 2'($urandom);
      return a;
   endfunction

   // One clock cycle: drive requesters, predict and compare, then advance the model.
   task automatic run_cycle(input int f_pct, input int d_pct, input int oor_pct, input logic rst);
      logic        exp_fv, exp_dv, exp_fg, exp_dg, fw, oor;
      logic [30:0] ga;
      int          ws;
      @(posedge clk);
      cyc++;
      #1;
      reset = rst;
      if (rst) begin
         f_pend = 1'b0;
         d_pend = 1'b0;
      end else if (!prev_rst) begin
         if (!f_pend && int'($urandom_range(99)) < f_pct) begin
            f_pend = 1'b1;
            f_a    = rand_addr(oor_pct);
         end
         if (!d_pend && int'($urandom_range(99)) < d_pct) begin
            d_pend = 1'b1;
            d_a    = rand_addr(oor_pct);
         end
      end
      bus.f_req  = f_pend;
      bus.f_addr = f_pend ? f_a : 31'($urandom);
      bus.d_req  = d_pend;
      bus.d_addr = d_pend ? d_a : 31'($urandom);
      @(negedge clk);

      exp_fv = 1'b0;
      exp_dv = 1'b0;
      while (evq.size() > 0 && evq[0].done == cyc) begin
         ev_t e;
         e = evq.pop_front();
         if (e.port) begin
            exp_dv = 1'b1; exp_d_rdata = e.data; exp_d_err = e.err;
         end else begin
            exp_fv = 1'b1; exp_f_rdata = e.data; exp_f_err = e.err;
         end
      end
      exp_fg = 1'b0;
      exp_dg = 1'b0;
      if (cyc >= free_cyc && !rst && (f_pend || d_pend)) begin
         fw     = f_pend && (starve == SL || !d_pend);
         exp_fg = fw;
         exp_dg = !fw;
      end

      check_eq("f_gnt",    32'(bus.f_gnt),    32'(exp_fg));
      check_eq("d_gnt",    32'(bus.d_gnt),    32'(exp_dg));
      check_eq("f_rvalid", 32'(bus.f_rvalid), 32'(exp_fv));
      check_eq("d_rvalid", 32'(bus.d_rvalid), 32'(exp_dv));
      check_eq("f_rdata",  bus.f_rdata,       exp_f_rdata);
      check_eq("d_rdata",  bus.d_rdata,       exp_d_rdata);
      check_eq("f_err",    32'(bus.f_err),    32'(exp_f_err));
      check_eq("d_err",    32'(bus.d_err),    32'(exp_d_err));
      check_eq("rom_addr", 32'(bus.rom_addr), 32'(exp_rom_addr));
      check_eq("busy",     32'(bus.busy),     32'(cyc < free_cyc));

      if (rst) begin
         evq.delete();
         free_cyc     = cyc + 1;
         starve       = 0;
         exp_f_rdata  = '0;
         exp_d_rdata  = '0;
         exp_f_err    = 1'b0;
         exp_d_err    = 1'b0;
         exp_rom_addr = '0;
      end else if (exp_fg || exp_dg) begin
         ga  = exp_fg ? f_a : d_a;
         oor = 1'b0;
`ifdef IMEM_ARB_RANGE_CHK_EN
         oor = (int'(ga[30:2]) >= RW);
`endif
         ws = oor ? 0 : WS;
         evq.push_back('{cyc + 2 + ws, exp_dg, oor ? 32'd0 : rom_mem[ga[7:2]], oor});
         free_cyc     = cyc + 2 + ws;
         exp_rom_addr = ga;
         last_grant   = cyc;
         if (exp_fg) begin
            starve = 0;
            f_pend = 1'b0;
         end else begin
            if (f_pend && starve < 15) starve++;
            d_pend = 1'b0;
         end
      end
      prev_rst = rst;
   endtask

   initial begin
      int waited;
      for (int i = 0; i < 64; i++) rom_mem[i] = $urandom;
      reset      = 1'b1;
      bus.f_req  = 1'b0;
      bus.f_addr = '0;
      bus.d_req  = 1'b0;
      bus.d_addr = '0;

      for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 1'b1);
      for (int i = 0; i < 4; i++) run_cycle(0, 0, 0, 1'b0);
      // Both ports saturated: starvation guard sets the grant rhythm.
      for (int i = 0; i < 60; i++) run_cycle(100, 100, 0, 1'b0);
      for (int i = 0; i < 300; i++) run_cycle(30, 30, 20, 1'b0);
      for (int i = 0; i < 80; i++) run_cycle(100, 100, 30, 1'b0);

      // Reset during the second ACCESS cycle of a fresh grant.
      for (int k = 0; k < 5; k++) begin
         waited = 0;
         while (evq.size() != 0 || cyc < free_cyc) begin
            run_cycle(0, 0, 0, 1'b0);
            waited++;
            if (waited > 40) break;
         end
         waited = 0;
         do begin
            run_cycle(60, 60, 0, 1'b0);
            waited++;
         end while (last_grant != cyc && waited < 50);
         n_checks++;
         if (last_grant != cyc) begin
            n_fail++;
            $display("FAIL grant_wait cyc=%0d got=no grant expected=grant within 50 cycles", cyc);
         end
         run_cycle(0, 0, 0, 1'b0);
         run_cycle(0, 0, 0, 1'b1);
         for (int i = 0; i < 12; i++) run_cycle(40, 40, 10, 1'b0);
      end

      for (int i = 0; i < 200; i++) run_cycle(50, 50, 15, 1'b0);
      for (int i = 0; i < 10; i++) run_cycle(0, 0, 0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
